mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory (256 x 32, byte-masked writes, 1-cycle registered read) between the instruction-fetch port and the data load/store port.
- Sits between the core front end / LSU and the memory instance. Replaces the separate instruction and data memory tops in the unified-memory build.
- Data port has priority. The fetch port is protected by a starvation counter. Read responses are returned to the owning port with a 1-cycle valid pulse.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_arb_prio.sv | 21 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

    // Encodes what was issued to memory in the previous cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } arb_state_t;

    localparam int unsigned C_MAX_WAIT = 4;

    function automatic int unsigned mask_width(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    import mem_arb_pkg::*;

    localparam int unsigned MW = mask_width(DW);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_mask;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_request;
    logic          mem_we_re;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [MW-1:0] mem_mask;
    logic [DW-1:0] mem_data_out;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        output d_gnt, d_rvalid, d_rdata,
        output mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        input  mem_data_out
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        output mem_data_out
    );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational priority picker: forced fetch, then data, then fetch
module mem_arb_prio (
    input  logic       if_req,
    input  logic       d_req,
    input  logic       force_if,
    output logic [1:0] gnt
);

    // gnt[0] = fetch, gnt[1] = data; at most one bit set
    always_comb begin
        gnt = 2'b00;
        if (force_if) begin
            gnt = 2'b01;
        end else if (d_req) begin
            gnt = 2'b10;
        end else if (if_req) begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = C_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [3:0]          starve_cnt
);

    localparam int unsigned MW = mask_width(DW);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [3:0]    r_starve_cnt;
    logic [3:0]    w_starve_nxt;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_force_if;
    logic [1:0]    w_gnt;
    logic          w_mem_request;
    logic          w_mem_we_re;
    logic [AW-1:0] w_mem_address;
    logic [DW-1:0] w_mem_data_in;
    logic [MW-1:0] w_mem_mask;

    assign w_force_if = bus.if_req && (r_starve_cnt >= 4'(MAX_WAIT));

    mem_arb_prio u_prio (
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .force_if (w_force_if),
        .gnt      (w_gnt)
    );

    // Winner drives the memory in the same cycle; idle bus is held at zero
    always_comb begin
        w_mem_request = 1'b0;
        w_mem_we_re   = 1'b0;
        w_mem_address = '0;
        w_mem_data_in = '0;
        w_mem_mask    = '0;
        w_state_nxt   = IDLE;
        if (w_gnt[0]) begin
            w_mem_request = 1'b1;
            w_mem_address = bus.if_addr;
            w_state_nxt   = IF_RD;
        end else if (w_gnt[1]) begin
            w_mem_request = 1'b1;
            w_mem_we_re   = bus.d_we;
            w_mem_address = bus.d_addr;
            w_mem_data_in = bus.d_wdata;
            w_mem_mask    = bus.d_mask;
            w_state_nxt   = bus.d_we ? D_WR : D_RD;
        end
    end

    always_comb begin
        w_starve_nxt = 4'd0;
        if (bus.if_req && !w_gnt[0]) begin
            w_starve_nxt = (r_starve_cnt == 4'd15) ? 4'd15 : r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (r_state == IF_RD) begin
                r_if_rdata <= bus.mem_data_out;
            end
            if (r_state == D_RD) begin
                r_d_rdata <= bus.mem_data_out;
            end
        end
    end

    assign bus.if_gnt      = w_gnt[0];
    assign bus.d_gnt       = w_gnt[1];
    assign bus.mem_request = w_mem_request;
    assign bus.mem_we_re   = w_mem_we_re;
    assign bus.mem_address = w_mem_address;
    assign bus.mem_data_in = w_mem_data_in;
    assign bus.mem_mask    = w_mem_mask;

    // Read data is forwarded straight from memory in the response cycle, then held
    assign bus.if_rvalid = (r_state == IF_RD);
    assign bus.d_rvalid  = (r_state == D_RD);
    assign bus.if_rdata  = (r_state == IF_RD) ? bus.mem_data_out : r_if_rdata;
    assign bus.d_rdata   = (r_state == D_RD)  ? bus.mem_data_out : r_d_rdata;

    assign starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with a memory model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  starve_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    mem_port_arbiter_if #(.AW(8), .DW(32)) bus ();

    mem_port_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .starve_cnt (starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port memory: byte-masked write, registered read
    always @(posedge clk) begin
        if (bus.mem_request) begin
            if (bus.mem_we_re) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
                end
            end else begin
                bus.mem_data_out <= mem[bus.mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = a;
        bus.d_wdata = d;
        bus.d_mask  = m;
        #1;
        chk("st_gnt", bus.d_gnt, 1);
        chk("st_mem_req", bus.mem_request, 1);
        chk("st_mem_we", bus.mem_we_re, 1);
        chk("st_mem_addr", bus.mem_address, a);
        chk("st_mem_data", bus.mem_data_in, d);
        chk("st_mem_mask", bus.mem_mask, m);
        tick();
    endtask

    logic [9:0]  exp_if_gnt = 10'b10000_10000;
    logic [3:0]  exp_cnt [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 32'h0;
        bus.d_mask  = 4'h0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_starve", starve_cnt, 0);
        chk("rst_state", dut.r_state, IDLE);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_mem_req", bus.mem_request, 0);
        tick();
        tick();
        rst = 1'b1;

        // Preload through the data port
        do_store(8'h10, 32'hDEADBEEF, 4'hF);
        do_store(8'h01, 32'hCAFE0001, 4'hF);
        do_store(8'h02, 32'h12345678, 4'hF);
        bus.d_req = 1'b0;
        #1;
        chk("st_no_rvalid", bus.d_rvalid, 0);
        chk("idle_mem_req", bus.mem_request, 0);
        tick();

        // Fetch only
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        #1;
        chk("f_if_gnt", bus.if_gnt, 1);
        chk("f_d_gnt", bus.d_gnt, 0);
        chk("f_mem_we", bus.mem_we_re, 0);
        chk("f_mem_mask", bus.mem_mask, 0);
        chk("f_mem_addr", bus.mem_address, 8'h10);
        tick();
        bus.if_req = 1'b0;
        #1;
        chk("f_if_rvalid", bus.if_rvalid, 1);
        chk("f_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f_d_rvalid", bus.d_rvalid, 0);
        tick();
        chk("f_rvalid_pulse", bus.if_rvalid, 0);
        chk("f_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

        // Masked store then load of the same word
        do_store(8'h20, 32'hAABBCCDD, 4'b0101);
        bus.d_we = 1'b0;
        #1;
        chk("ld_gnt", bus.d_gnt, 1);
        chk("ld_mem_we", bus.mem_we_re, 0);
        chk("ld_after_st_rvalid", bus.d_rvalid, 0);
        tick();
        bus.d_req = 1'b0;
        #1;
        chk("ld_rvalid", bus.d_rvalid, 1);
        chk("ld_rdata", bus.d_rdata, 32'h00BB00DD);
        tick();

        // Contention with both requests held
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h01;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h02;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("ct_if_gnt_%0d", c), bus.if_gnt, exp_if_gnt[c]);
            chk($sformatf("ct_d_gnt_%0d", c), bus.d_gnt, !exp_if_gnt[c]);
            chk($sformatf("ct_cnt_%0d", c), starve_cnt, exp_cnt[c]);
            if (c > 0) begin
                chk($sformatf("ct_if_rvalid_%0d", c), bus.if_rvalid, exp_if_gnt[c-1]);
                chk($sformatf("ct_d_rvalid_%0d", c), bus.d_rvalid, !exp_if_gnt[c-1]);
                if (exp_if_gnt[c-1]) chk($sformatf("ct_if_rdata_%0d", c), bus.if_rdata, 32'h12345678);
                else                 chk($sformatf("ct_d_rdata_%0d", c), bus.d_rdata, 32'hCAFE0001);
            end
            tick();
        end
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        #1;
        chk("ct_last_if_rvalid", bus.if_rvalid, 1);
        chk("ct_last_cnt", starve_cnt, 0);
        tick();

        // Back-to-back alternating load 0x01 / fetch 0x02
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h01;
        #1;
        chk("bb0_d_gnt", bus.d_gnt, 1);
        tick();
        bus.d_req  = 1'b0;
        bus.if_req = 1'b1;
        #1;
        chk("bb1_if_gnt", bus.if_gnt, 1);
        chk("bb1_d_rvalid", bus.d_rvalid, 1);
        chk("bb1_d_rdata", bus.d_rdata, 32'hCAFE0001);
        chk("bb1_if_rvalid", bus.if_rvalid, 0);
        tick();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b1;
        #1;
        chk("bb2_d_gnt", bus.d_gnt, 1);
        chk("bb2_if_rvalid", bus.if_rvalid, 1);
        chk("bb2_if_rdata", bus.if_rdata, 32'h12345678);
        chk("bb2_d_rvalid", bus.d_rvalid, 0);
        tick();
        bus.d_req  = 1'b0;
        bus.if_req = 1'b1;
        #1;
        chk("bb3_if_gnt", bus.if_gnt, 1);
        chk("bb3_d_rvalid", bus.d_rvalid, 1);
        chk("bb3_if_rvalid", bus.if_rvalid, 0);
        tick();
        bus.if_req = 1'b0;
        #1;
        chk("bb4_if_rvalid", bus.if_rvalid, 1);
        chk("bb4_d_rvalid", bus.d_rvalid, 0);
        chk("bb4_mem_req", bus.mem_request, 0);
        tick();
        chk("bb5_if_rvalid", bus.if_rvalid, 0);
        chk("bb5_d_rvalid", bus.d_rvalid, 0);

        // Reset while a load response is in flight
        bus.d_req   = 1'b1;
        bus.d_addr  = 8'h20;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        #1;
        chk("rm_d_gnt", bus.d_gnt, 1);
        tick();
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rm_d_rvalid", bus.d_rvalid, 0);
        chk("rm_d_rdata", bus.d_rdata, 0);
        chk("rm_if_rdata", bus.if_rdata, 0);
        chk("rm_starve", starve_cnt, 0);
        chk("rm_state", dut.r_state, IDLE);
        #1 rst = 1'b1;
        tick();
        chk("rm_post_rvalid", bus.d_rvalid, 0);
        bus.d_req = 1'b1;
        #1;
        chk("rm_re_gnt", bus.d_gnt, 1);
        tick();
        bus.d_req = 1'b0;
        #1;
        chk("rm_re_rvalid", bus.d_rvalid, 1);
        chk("rm_re_rdata", bus.d_rdata, 32'h00BB00DD);
        tick();

        // Fetch withdraws after losing twice
        bus.d_req   = 1'b1;
        bus.d_addr  = 8'h01;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h02;
        #1;
        chk("wd0_cnt", starve_cnt, 0);
        chk("wd0_d_gnt", bus.d_gnt, 1);
        tick();
        chk("wd1_cnt", starve_cnt, 1);
        chk("wd1_if_gnt", bus.if_gnt, 0);
        tick();
        bus.if_req = 1'b0;
        #1;
        chk("wd2_cnt", starve_cnt, 2);
        tick();
        chk("wd3_cnt", starve_cnt, 0);
        bus.d_req = 1'b0;
        #1;
        chk("wd_mem_req", bus.mem_request, 0);
        chk("wd_mem_addr", bus.mem_address, 0);
        chk("wd_if_gnt", bus.if_gnt, 0);
        chk("wd_d_gnt", bus.d_gnt, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
